// File: rtl/main_ctrl_fsm_pkg.sv
// Shared state codes, ALU control op encodings and opcode/funct constants
// for the multicycle main controller.
package main_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_R   = 4'd2,
    S_EXE_I   = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_R    = 4'd7,
    S_WB_I    = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [1:0] ALUCTRL_ADD4   = 2'b00;
  localparam logic [1:0] ALUCTRL_RTYPE  = 2'b01;
  localparam logic [1:0] ALUCTRL_ITYPE  = 2'b10;
  localparam logic [1:0] ALUCTRL_BRANCH = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational instruction-decode step: next state out of S_ID plus
// opcode legality, derived from OP/funct.
module main_ctrl_decode
  import main_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output state_t     next_state,
  output logic       legal
);

  always_comb begin
    legal      = 1'b1;
    next_state = S_IF;
    case (op)
      OP_RTYPE: next_state = (funct == FUNCT_JR) ? S_JUMP : S_EXE_R;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU:
                next_state = S_EXE_I;
      OP_LW, OP_SW:   next_state = S_MEM_ADR;
      OP_BEQ, OP_BNE: next_state = S_BRANCH;
      OP_J, OP_JAL:   next_state = S_JUMP;
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle main controller: IF/ID/EXE/MEM/WB sequencing, datapath strobes,
// retire counter. Define ILLEGAL_TRAP_EN to trap illegal opcodes in S_TRAP.
//
//  state     | meaning
//  S_IF      | fetch, wait for mem_ready, PC <= PC+4
//  S_ID      | decode, branch target into ALUOut
//  S_EXE_R   | R-type ALU op
//  S_EXE_I   | I-type ALU op
//  S_MEM_ADR | load/store address calc
//  S_MEM_RD  | load access, wait for mem_ready
//  S_MEM_WR  | store access, wait for mem_ready
//  S_WB_R    | R-type writeback to rd
//  S_WB_I    | I-type writeback to rt
//  S_WB_MEM  | load writeback to rt
//  S_BRANCH  | BEQ/BNE compare and conditional PC load
//  S_JUMP    | J/JAL/JR PC load, JAL links $31
//  S_TRAP    | illegal opcode, held until reset
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OP,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUCtrlOp,
  output logic [3:0]         state_o,
  output logic               instr_retired,
  output logic [COUNT_W-1:0] instr_count,
  output logic               exc_illegal
);

  state_t state, next_state, id_next;
  logic   id_legal;
  logic   retire;

  main_ctrl_decode u_decode (
    .op         (OP),
    .funct      (funct),
    .next_state (id_next),
    .legal      (id_legal)
  );

  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF:      next_state = mem_ready ? S_ID : S_IF;
`ifdef ILLEGAL_TRAP_EN
      S_ID:      next_state = id_legal ? id_next : S_TRAP;
`else
      S_ID:      next_state = id_legal ? id_next : S_IF;
`endif
      S_EXE_R:   next_state = S_WB_R;
      S_EXE_I:   next_state = S_WB_I;
      S_MEM_ADR: next_state = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  next_state = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:  next_state = mem_ready ? S_IF : S_MEM_WR;
      S_TRAP:    next_state = S_TRAP;
      default:   next_state = S_IF;
    endcase
  end

  assign retire  = (state != S_IF) && (next_state == S_IF);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IF;
      instr_retired <= 1'b0;
      instr_count   <= '0;
    end else begin
      state         <= next_state;
      instr_retired <= retire;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) exc_illegal <= 1'b0;
    else if (next_state == S_TRAP) exc_illegal <= 1'b1;
  end
`else
  assign exc_illegal = 1'b0;
`endif

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ExtOp       = 1'b0;
    PCSource    = 2'b00;
    ALUCtrlOp   = ALUCTRL_ADD4;
    case (state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_ID: ALUSrcB = 2'b11;
      S_EXE_R: begin
        ALUSrcA   = 1'b1;
        ALUCtrlOp = ALUCTRL_RTYPE;
      end
      S_EXE_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUCtrlOp = ALUCTRL_ITYPE;
        ExtOp     = !is_zext_op(OP);
      end
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_R: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end
      S_WB_I: RegWrite = 1'b1;
      S_WB_MEM: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUCtrlOp   = ALUCTRL_BRANCH;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (OP == OP_BNE);
      end
      S_JUMP: begin
        // Only JR reaches S_JUMP with an R-type opcode.
        PCWrite  = 1'b1;
        PCSource = (OP == OP_RTYPE) ? 2'b11 : 2'b10;
        if (OP == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      default: ;
    endcase
  end

endmodule
